// File: rtl/audio_pkg.sv
// Shared types and constants for the audio beat sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

    localparam int BEAT_W            = 8;
    localparam int BEAT_FREQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/beat_tick_gen.sv
// Beat divider: counts 0..DIV-1 while en=1 and pulses tick on the terminal count.
// Latency: tick is combinational from the count register, valid in the terminal cycle.
// Backpressure: none; en=0 freezes the count, clr forces it back to 0.
module beat_tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Song beat sequencer: steps ibeat at BEAT_FREQ, loops or finishes at LEN-1.
// Latency: all outputs registered; ibeat/beat_tick update one cycle after the divider tick.
// Backpressure: pause (only with BEAT_SEQ_PAUSE_EN defined) freezes divider and ibeat.
module beat_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BEAT_FREQ = BEAT_FREQ_DEFAULT,
    parameter int LEN       = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              loop,
    input  logic              pause,
    output logic [BEAT_W-1:0] ibeat,
    output logic              beat_tick,
    output logic              busy,
    output logic              done
);

    localparam int               DIV       = CLK_FREQ / BEAT_FREQ;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LEN - 1);

    seq_state_t        state_q, state_d;
    logic [BEAT_W-1:0] ibeat_q, ibeat_d;
    logic              beat_tick_q, beat_tick_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_en;
    logic              tick_clr;
    logic              tick;

    // The divider only runs in cycles that stay in PLAY, so a tick landing on
    // a pause or stop edge never fires and the count is frozen where it was.
`ifdef BEAT_SEQ_PAUSE_EN
    assign tick_en = (state_q == PLAY) && play && !pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign tick_en      = (state_q == PLAY) && play;
`endif

    assign tick_clr = (state_q == IDLE) || (state_d == IDLE);

    beat_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ibeat_q     <= '0;
            beat_tick_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ibeat_q     <= ibeat_d;
            beat_tick_q <= beat_tick_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (play) state_d = PLAY;
            end
            PLAY: begin
                if (!play) begin
                    state_d = IDLE;
`ifdef BEAT_SEQ_PAUSE_EN
                end else if (pause) begin
                    state_d = PAUSE;
`endif
                end else if (tick && (ibeat_q == LAST_BEAT) && !loop) begin
                    state_d = IDLE;
                end
            end
`ifdef BEAT_SEQ_PAUSE_EN
            PAUSE: begin
                if (!play) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = PLAY;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Leaving PLAY for IDLE with play still high can only be song completion.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == PLAY) && (state_d == IDLE) && play;
        beat_tick_d = (state_q == PLAY) && (state_d == PLAY) && tick;
        ibeat_d     = ibeat_q;
        if (state_d == IDLE) begin
            ibeat_d = '0;
        end else if (beat_tick_d) begin
            ibeat_d = (ibeat_q == LAST_BEAT) ? '0 : ibeat_q + BEAT_W'(1);
        end
    end

    assign ibeat     = ibeat_q;
    assign beat_tick = beat_tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with DIV=8, LEN=4; pause scenario when BEAT_SEQ_PAUSE_EN is set.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_beat_sequencer;

    localparam int CLK_FREQ  = 16;
    localparam int BEAT_FREQ = 2;
    localparam int LEN       = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       play;
    logic       loop;
    logic       pause;
    logic [7:0] ibeat;
    logic       beat_tick;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    bit wiggle_pause = 1'b0;

    always #5 clk = ~clk;

    beat_sequencer #(
        .CLK_FREQ  (CLK_FREQ),
        .BEAT_FREQ (BEAT_FREQ),
        .LEN       (LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .loop      (loop),
        .pause     (pause),
        .ibeat     (ibeat),
        .beat_tick (beat_tick),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (wiggle_pause) pause = ~pause;
        end
    endtask

    // Cycles until the next beat_tick or done, bounded at 40.
    task automatic wait_beat(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(beat_tick || done) && n < 40);
    endtask

    task automatic run_single(input string p);
        int n;
        play = 1'b1;
        loop = 1'b0;
        step(1);
        check({p, "_start_busy"}, int'(busy), 1);
        check({p, "_start_ibeat"}, int'(ibeat), 0);
        check({p, "_start_tick"}, int'(beat_tick), 0);
        for (int k = 1; k <= 3; k++) begin
            wait_beat(n);
            check({p, "_spacing"}, n, 8);
            check({p, "_ibeat"}, int'(ibeat), k);
            check({p, "_tick"}, int'(beat_tick), 1);
            check({p, "_no_done"}, int'(done), 0);
        end
        wait_beat(n);
        check({p, "_end_spacing"}, n, 8);
        check({p, "_end_done"}, int'(done), 1);
        check({p, "_end_tick"}, int'(beat_tick), 0);
        check({p, "_end_ibeat"}, int'(ibeat), 0);
        check({p, "_end_busy"}, int'(busy), 0);
        play = 1'b0;
        step(1);
        check({p, "_done_once"}, int'(done), 0);
        check({p, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int ticks;
        int dones;
        int k;

        rst   = 1'b1;
        play  = 1'b0;
        loop  = 1'b0;
        pause = 1'b0;
        step(2);
        check("rst_ibeat", int'(ibeat), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(beat_tick), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        step(3);
        check("idle_busy", int'(busy), 0);

        // Single non-looped song
        run_single("single");

        // Looped song over 64 cycles
        play = 1'b1;
        loop = 1'b1;
        step(1);
        ticks = 0;
        dones = 0;
        k     = 0;
        for (int c = 0; c < 64; c++) begin
            step(1);
            if (beat_tick) begin
                k++;
                ticks++;
                check("loop_seq", int'(ibeat), k % 4);
            end
            if (done) dones++;
        end
        check("loop_tick_count", ticks, 8);
        check("loop_done_count", dones, 0);
        play = 1'b0;
        step(1);
        check("loop_stop_busy", int'(busy), 0);
        check("loop_stop_ibeat", int'(ibeat), 0);

        // Stop at ibeat=3 on the cycle the divider reaches its terminal count
        play = 1'b1;
        loop = 1'b0;
        step(1);
        repeat (3) wait_beat(n);
        check("stop_pre_ibeat", int'(ibeat), 3);
        step(7);
        play = 1'b0;
        step(1);
        check("stop_busy", int'(busy), 0);
        check("stop_ibeat", int'(ibeat), 0);
        check("stop_done", int'(done), 0);
        check("stop_tick", int'(beat_tick), 0);
        step(1);
        check("stop_done_late", int'(done), 0);

        // Reset mid-song with play held high
        play = 1'b1;
        loop = 1'b1;
        step(1);
        wait_beat(n);
        check("mrst_pre_ibeat", int'(ibeat), 1);
        step(3);
        rst = 1'b1;
        step(1);
        check("mrst_ibeat", int'(ibeat), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_tick", int'(beat_tick), 0);
        check("mrst_done", int'(done), 0);
        rst = 1'b0;
        step(1);
        check("mrst_restart_busy", int'(busy), 1);
        check("mrst_restart_ibeat", int'(ibeat), 0);
        wait_beat(n);
        check("mrst_restart_spacing", n, 8);
        check("mrst_restart_ibeat1", int'(ibeat), 1);
        play = 1'b0;
        step(1);

`ifdef BEAT_SEQ_PAUSE_EN
        // Pause at ibeat=2 with the divider at 5
        play = 1'b1;
        loop = 1'b0;
        step(1);
        repeat (2) wait_beat(n);
        check("pause_pre_ibeat", int'(ibeat), 2);
        step(5);
        pause = 1'b1;
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (beat_tick) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_ibeat", int'(ibeat), 2);
        check("pause_busy", int'(busy), 1);
        pause = 1'b0;
        step(1);
        check("resume_busy", int'(busy), 1);
        check("resume_ibeat", int'(ibeat), 2);
        wait_beat(n);
        check("resume_spacing", n, 3);
        check("resume_ibeat3", int'(ibeat), 3);
        pause = 1'b1;
        step(2);
        play = 1'b0;
        step(1);
        check("pause_stop_busy", int'(busy), 0);
        check("pause_stop_ibeat", int'(ibeat), 0);
        check("pause_stop_done", int'(done), 0);
        pause = 1'b0;
        step(1);
`else
        // pause toggling every cycle must not disturb timing
        wiggle_pause = 1'b1;
        run_single("nopause");
        wiggle_pause = 1'b0;
        pause = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beat_sequencer.md
BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BEAT_FREQ, 8, beat rate in Hz; one beat is 1/8 s.
- LEN, 128, beats per song, range 2..256.
REQ-002 The block SHALL have these ports:
- clk  in  1  single system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- play  in  1  level; 1 = run the song, 0 = stop.
- loop  in  1  level; sampled at the last beat.
- pause  in  1  level; 1 = hold the current beat.
- ibeat  out  8  current beat index, feeds the tone ROM.
- beat_tick  out  1  one-cycle pulse on every ibeat change caused by beat advance.
- busy  out  1  1 while in the PLAY or PAUSE state.
- done  out  1  one-cycle pulse on non-looped song completion.

Function
REQ-003 The block SHALL have internal divider constant DIV = CLK_FREQ/BEAT_FREQ, using integer division.
REQ-004 The block SHALL run a divider counter 0..DIV-1 in clk; the internal tick is asserted in the cycle where counter==DIV-1, and the counter then wraps to 0.
REQ-005 The block SHALL have three states: IDLE, PLAY and PAUSE.
REQ-006 In IDLE, the block SHALL hold ibeat=0, busy=0 and the divider counter at 0.
REQ-007 IDLE with play=1 SHALL go to PLAY next cycle, with ibeat=0, the divider starting from 0, and no beat_tick.
REQ-008 In PLAY, each tick SHALL increment ibeat by 1 and pulse beat_tick in the same registered cycle as the ibeat update.
REQ-009 In PLAY, a tick with ibeat==LEN-1 SHALL behave as follows:
- loop=1: ibeat becomes 0, beat_tick pulses, and the state stays PLAY.
- loop=0: the state goes to IDLE, ibeat becomes 0, done pulses for one cycle, and beat_tick stays 0.
REQ-010 PLAY with play=0 SHALL go to IDLE next cycle, with ibeat=0 and no done; play=0 has priority over tick, pause and loop.
REQ-011 PLAY with play=1 and pause=1 SHALL go to PAUSE next cycle; a tick coinsident with the pause edge is discarded (ibeat unchanged).
REQ-012 In PAUSE, the divider counter and ibeat SHALL be frozen and busy SHALL stay 1.
REQ-013 In PAUSE, pause=0 SHALL return to PLAY, and the divider SHALL resume from its frozen value.
REQ-014 In PAUSE, play=0 SHALL go to IDLE, ibeat=0, with no done.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 ibeat SHALL never reach a value of LEN or greater.
REQ-017 ibeat SHALL be zero-extended to 8 bits when LEN is 256 or less.
REQ-018 done and beat_tick SHALL never be asserted in the same cycle.

Reset
REQ-019 When rst=1 at a clk edge, the block SHALL enter IDLE, clear the divider, and set ibeat=0, beat_tick=0, busy=0 and done=0.
REQ-020 Reset SHALL take priority over all inputs, including when asserted mid-song or in PAUSE; no done pulse is produced.
REQ-021 After reset release with play=1 held, the song SHALL start per REQ-007 on the first non-reset edge.

Configuration
REQ-022 With macro BEAT_SEQ_PAUSE_EN defined, the pause input and the PAUSE state SHALL be implemented per REQ-011..REQ-014.
REQ-023 Without BEAT_SEQ_PAUSE_EN, the pause port SHALL remain present but be ignored, and the PAUSE state SHALL be absent, so that PLAY only exits via play=0, completion, or rst.

Structure
REQ-024 Shared package audio_pkg SHALL hold:
- BEAT_W=8;
- the state enum {IDLE, PLAY, PAUSE};
- default BEAT_FREQ=8.
REQ-025 The divider SHALL be a sub-module named beat_tick_gen, with inputs clk, rst, en and clr, and output tick.
REQ-026 No derived clock SHALL be generated; beats SHALL be conveyed only by the enable pulse.

Verification
All scenarios use CLK_FREQ=16, BEAT_FREQ=2 (DIV=8) and LEN=4.
REQ-027 Scenario: play=1, loop=0 from IDLE -> busy=1 next cycle; ibeat steps 1,2,3 at 8-cycle spacing with beat_tick; on the 4th tick ibeat=0, done pulses once, busy=0.
REQ-028 Scenario: play=1, loop=1 -> ibeat sequence 1,2,3,0,1,... with no done; beat_tick count after 64 cycles equals 8.
REQ-029 Scenario: pause=1 for 20 cycles at ibeat=2, counter=5 -> ibeat holds 2; after release, the next tick arrives 3 cycles later.
REQ-030 Scenario: play dropped at ibeat=3, coinciding with a tick -> IDLE next cycle, ibeat=0, done=0.
REQ-031 Scenario: rst pulsed for 1 cycle mid-song with play held 1 -> all outputs 0 in the reset cycle, and the song restarts with ibeat=0.
REQ-032 Scenario: build without BEAT_SEQ_PAUSE_EN, toggle pause during play -> ibeat timing is identical to REQ-027.
